// File: rtl/decode_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// The decode stage uses the slave modport; the fetch/execute environment uses master.
interface decode_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OPCODE_WIDTH   = 7
);
    logic                      if_valid;
    logic                      if_ready;
    logic [DATA_WIDTH-1:0]     pc_in;
    logic [31:0]               instr_in;

    logic                      id_valid;
    logic                      id_ready;
    logic [DATA_WIDTH-1:0]     pc_out;
    logic [DATA_WIDTH-1:0]     rs1_out;
    logic [DATA_WIDTH-1:0]     rs2_out;
    logic [DATA_WIDTH-1:0]     imm_out;
    logic [OPCODE_WIDTH-1:0]   opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic                      illegal;

    modport slave (
        input  if_valid, pc_in, instr_in, id_ready,
        output if_ready, id_valid, pc_out, rs1_out, rs2_out, imm_out,
               opcode, funct3, funct7, rd_addr, illegal
    );

    modport master (
        output if_valid, pc_in, instr_in, id_ready,
        input  if_ready, id_valid, pc_out, rs1_out, rs2_out, imm_out,
               opcode, funct3, funct7, rd_addr, illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: 2R1W register file, immediate generation and a single
// registered output slot with valid/ready on both sides and writeback bypass.
module decode_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OPCODE_WIDTH   = 7
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      flush_i,
    input  logic                      wb_en_i,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr_i,
    input  logic [DATA_WIDTH-1:0]     wb_data_i,
    decode_if.slave                   bus
);
    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [DATA_WIDTH-1:0]     rf_q [NUM_REGS];

    logic                      valid_q, valid_d;
    logic [DATA_WIDTH-1:0]     pc_q, rs1_q, rs2_q, imm_q;
    logic [OPCODE_WIDTH-1:0]   opcode_q;
    logic [2:0]                funct3_q;
    logic [6:0]                funct7_q;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rs1_idx_q, rs2_idx_q;
    logic                      illegal_q;

    logic [31:0]               instr;
    logic [REG_ADDR_WIDTH-1:0] rs1_idx, rs2_idx;
    logic [DATA_WIDTH-1:0]     rs1_rd, rs2_rd;
    logic [31:0]               imm_d;
    logic [6:0]                funct7_d;
    logic                      illegal_d;
    logic                      accept, load;

    assign instr   = bus.instr_in;
    assign rs1_idx = instr[19:15];
    assign rs2_idx = instr[24:20];

    assign bus.if_ready = !valid_q || bus.id_ready;
    assign accept       = bus.if_valid && bus.if_ready;
    assign load         = accept && !flush_i;

    always_comb begin
        if (flush_i)          valid_d = 1'b0;
        else if (accept)      valid_d = 1'b1;
        else if (bus.id_ready) valid_d = 1'b0;
        else                  valid_d = valid_q;
    end

    // Reads bypass a same-cycle writeback so the bundle never carries a stale operand.
    always_comb begin
        rs1_rd = '0;
        rs2_rd = '0;
        if (rs1_idx != '0)
            rs1_rd = (wb_en_i && wb_addr_i == rs1_idx) ? wb_data_i : rf_q[rs1_idx];
        if (rs2_idx != '0)
            rs2_rd = (wb_en_i && wb_addr_i == rs2_idx) ? wb_data_i : rf_q[rs2_idx];
    end

    always_comb begin
        imm_d     = '0;
        funct7_d  = '0;
        illegal_d = 1'b0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                imm_d = {{20{instr[31]}}, instr[31:20]};
                // Only shifts carry funct7, so ADDI/ANDI never look like SUB/SRA.
                if (instr[14:12] == 3'b001 || instr[14:12] == 3'b101)
                    funct7_d = instr[31:25];
            end
            OPC_LOAD, OPC_JALR:
                imm_d = {{20{instr[31]}}, instr[31:20]};
            OPC_STORE:
                imm_d = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            OPC_BRANCH:
                imm_d = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm_d = {instr[31:12], 12'b0};
            OPC_JAL:
                imm_d = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            OPC_OP:
                funct7_d = instr[31:25];
            default:
                illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            imm_q     <= '0;
            opcode_q  <= '0;
            funct3_q  <= '0;
            funct7_q  <= '0;
            rd_q      <= '0;
            rs1_idx_q <= '0;
            rs2_idx_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (load) begin
                pc_q      <= bus.pc_in;
                rs1_q     <= rs1_rd;
                rs2_q     <= rs2_rd;
                imm_q     <= DATA_WIDTH'(imm_d);
                opcode_q  <= instr[OPCODE_WIDTH-1:0];
                funct3_q  <= instr[14:12];
                funct7_q  <= funct7_d;
                rd_q      <= instr[11:7];
                rs1_idx_q <= rs1_idx;
                rs2_idx_q <= rs2_idx;
                illegal_q <= illegal_d;
            end else if (valid_q && wb_en_i) begin
                // A held bundle tracks writebacks to its source registers.
                if (wb_addr_i == rs1_idx_q && rs1_idx_q != '0) rs1_q <= wb_data_i;
                if (wb_addr_i == rs2_idx_q && rs2_idx_q != '0) rs2_q <= wb_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (wb_en_i && wb_addr_i != '0) begin
            rf_q[wb_addr_i] <= wb_data_i;
        end
    end

    assign bus.id_valid = valid_q;
    assign bus.pc_out   = pc_q;
    assign bus.rs1_out  = rs1_q;
    assign bus.rs2_out  = rs2_q;
    assign bus.imm_out  = imm_q;
    assign bus.opcode   = opcode_q;
    assign bus.funct3   = funct3_q;
    assign bus.funct7   = funct7_q;
    assign bus.rd_addr  = rd_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a behavioural decode model.
module tb_decode_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    always #5 clk = ~clk;

    decode_if bus ();

    decode_stage dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .flush_i  (flush),
        .wb_en_i  (wb_en),
        .wb_addr_i(wb_addr),
        .wb_data_i(wb_data),
        .bus      (bus)
    );

    // Reference model state
    logic [31:0] m_rf [32];
    bit          m_valid;
    logic [31:0] m_pc, m_rs1, m_rs2, m_imm;
    logic [6:0]  m_opc, m_f7;
    logic [2:0]  m_f3;
    logic [4:0]  m_rd, m_s1, m_s2;
    bit          m_ill;

    int vectors = 0;
    int miscompares = 0;

    function automatic bit is_legal(input logic [6:0] opc);
        return opc inside {7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic signed [11:0] a;
        logic signed [12:0] b;
        logic signed [20:0] j;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin a = ins[31:20]; return 32'(a); end
            7'h23: begin a = {ins[31:25], ins[11:7]}; return 32'(a); end
            7'h63: begin b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; return 32'(b); end
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: begin j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; return 32'(j); end
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [6:0] ref_f7(input logic [31:0] ins);
        if (ins[6:0] == 7'h33) return ins[31:25];
        if (ins[6:0] == 7'h13 && (ins[14:12] == 3'd1 || ins[14:12] == 3'd5)) return ins[31:25];
        return 7'h0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (wb_en && wb_addr == idx) return wb_data;
        return m_rf[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
        m_valid = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0;
        m_opc = 0; m_f7 = 0; m_f3 = 0; m_rd = 0; m_s1 = 0; m_s2 = 0; m_ill = 0;
    endtask

    // Apply the rules for one rising edge using the inputs present before it.
    task automatic model_edge();
        bit accept, nv;
        logic [31:0] ins;
        ins    = bus.instr_in;
        accept = bus.if_valid && (!m_valid || bus.id_ready);
        if (flush)             nv = 0;
        else if (accept)       nv = 1;
        else if (bus.id_ready) nv = 0;
        else                   nv = m_valid;
        if (accept && !flush) begin
            m_pc  = bus.pc_in;
            m_s1  = ins[19:15];
            m_s2  = ins[24:20];
            m_rs1 = ref_read(m_s1);
            m_rs2 = ref_read(m_s2);
            m_imm = ref_imm(ins);
            m_opc = ins[6:0];
            m_f3  = ins[14:12];
            m_f7  = ref_f7(ins);
            m_rd  = ins[11:7];
            m_ill = !is_legal(ins[6:0]);
            $display("beat pc=%h instr=%h rs1=%h rs2=%h imm=%h ill=%0d", m_pc, ins, m_rs1, m_rs2, m_imm, m_ill);
        end else if (m_valid && nv && wb_en && wb_addr != 5'd0) begin
            if (wb_addr == m_s1) m_rs1 = wb_data;
            if (wb_addr == m_s2) m_rs2 = wb_data;
        end
        m_valid = nv;
        if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_all();
        check("id_valid", 32'(bus.id_valid), 32'(m_valid));
        check("if_ready", 32'(bus.if_ready), 32'(!m_valid || bus.id_ready));
        if (m_valid) begin
            check("pc_out",  bus.pc_out,  m_pc);
            check("rs1_out", bus.rs1_out, m_rs1);
            check("rs2_out", bus.rs2_out, m_rs2);
            check("imm_out", bus.imm_out, m_imm);
            check("opcode",  32'(bus.opcode),  32'(m_opc));
            check("funct3",  32'(bus.funct3),  32'(m_f3));
            check("funct7",  32'(bus.funct7),  32'(m_f7));
            check("rd_addr", 32'(bus.rd_addr), 32'(m_rd));
            check("illegal", 32'(bus.illegal), 32'(m_ill));
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input logic [31:0] ins, input bit rdy,
                         input bit fl, input bit we, input logic [4:0] wa, input logic [31:0] wd);
        bus.if_valid = v;
        bus.pc_in    = pc;
        bus.instr_in = ins;
        bus.id_ready = rdy;
        flush        = fl;
        wb_en        = we;
        wb_addr      = wa;
        wb_data      = wd;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    logic [6:0] opcs [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

    initial begin
        logic [31:0] ins;
        int r;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid",   32'(bus.id_valid), 32'h0);
        check("rst_pc",      bus.pc_out, 32'h0);
        check("rst_if_ready", 32'(bus.if_ready), 32'h1);
        rst_n = 1'b1;

        // writeback then addi x6,x5,-1
        drive(0, 0, 0, 1, 0, 1, 5'd5, 32'h0000_1234);
        cycle();
        drive(1, 32'h100, 32'hFFF2_8313, 1, 0, 0, 0, 0);
        cycle();
        check("t2_rs1",   bus.rs1_out, 32'h0000_1234);
        check("t2_imm",   bus.imm_out, 32'hFFFF_FFFF);
        check("t2_f7",    32'(bus.funct7), 32'h0);
        check("t2_rd",    32'(bus.rd_addr), 32'h6);

        // same-cycle bypass: add x8,x7,x0 with WB x7
        drive(1, 32'h104, 32'h0003_8433, 1, 0, 1, 5'd7, 32'hA5A5_A5A5);
        cycle();
        check("t3_rs1", bus.rs1_out, 32'hA5A5_A5A5);
        check("t3_rs2", bus.rs2_out, 32'h0);

        // backpressure and operand refresh of held bundle (rs1 = x5)
        drive(1, 32'h108, 32'h0012_8313, 1, 0, 0, 0, 0);
        cycle();
        drive(1, 32'h10C, 32'h0000_0013, 0, 0, 0, 0, 0);
        cycle();
        check("t4_if_ready", 32'(bus.if_ready), 32'h0);
        check("t4_pc_hold1", bus.pc_out, 32'h108);
        drive(1, 32'h10C, 32'h0000_0013, 0, 0, 1, 5'd5, 32'hDEAD_BEEF);
        cycle();
        check("t4_refresh", bus.rs1_out, 32'hDEAD_BEEF);
        check("t4_pc_hold2", bus.pc_out, 32'h108);
        drive(1, 32'h10C, 32'h0000_0013, 0, 0, 0, 0, 0);
        cycle();
        check("t4_pc_hold3", bus.pc_out, 32'h108);
        drive(1, 32'h10C, 32'h0000_0013, 1, 0, 0, 0, 0);
        cycle();
        check("t4_next_beat", bus.pc_out, 32'h10C);

        // branch immediate, then x0 write ignored
        drive(1, 32'h200, 32'hFE00_0EE3, 1, 0, 0, 0, 0);
        cycle();
        check("t5_imm", bus.imm_out, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, 0, 1, 5'd0, 32'hFFFF_FFFF);
        cycle();
        drive(1, 32'h204, 32'h0000_0033, 1, 0, 0, 0, 0);
        cycle();
        check("t5_x0_rs1", bus.rs1_out, 32'h0);
        check("t5_x0_rs2", bus.rs2_out, 32'h0);

        // illegal encoding, then flush with a same-cycle accept
        drive(1, 32'h300, 32'h0000_007F, 1, 0, 0, 0, 0);
        cycle();
        check("t6_illegal", 32'(bus.illegal), 32'h1);
        check("t6_valid",   32'(bus.id_valid), 32'h1);
        check("t6_imm",     bus.imm_out, 32'h0);
        drive(1, 32'h304, 32'h0000_0013, 1, 1, 0, 0, 0);
        cycle();
        check("t6_flush", 32'(bus.id_valid), 32'h0);

        // asynchronous reset in the middle of a held bundle
        drive(1, 32'h400, 32'h0012_8313, 0, 0, 0, 0, 0);
        cycle();
        check("t1_valid_pre", 32'(bus.id_valid), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t1_valid_async", 32'(bus.id_valid), 32'h0);
        check("t1_pc_async",    bus.pc_out, 32'h0);
        check("t1_rs1_async",   bus.rs1_out, 32'h0);
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 32'h404, 32'h0012_8313, 1, 0, 0, 0, 0);
        cycle();
        check("t1_rf_cleared", bus.rs1_out, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            ins = $urandom;
            r = $urandom_range(0, 9);
            if (r < 9) ins[6:0] = opcs[r];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            drive($urandom_range(0, 3) != 0, $urandom, ins, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
